hps_system_gpio_ctrl: RTL

//  Parametrised Avalon-MM slave GPIO controller; successor to the 8-bit output-only LED PIO.

---
 rtl/hps_system_gpio_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hps_system_gpio_ctrl.sv
// Avalon-MM GPIO controller: per-bit direction, synchronised inputs, edge capture
// with maskable level interrupt, atomic set/clear and hardware blink.
module hps_system_gpio_ctrl #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam int unsigned   PW        = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;
    localparam logic [2:0] A_BLINK  = 3'd6;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_blink_en;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_in_prev;
    logic [PW-1:0]    r_presc;
    logic             r_blink_phase;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_data_rd;
    logic             w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = &{1'b0, writedata};
    assign w_in_sync   = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_in_sync & ~r_in_prev;
    assign w_fall      = ~w_in_sync & r_in_prev;
    assign w_clr       = (w_wr && address == A_EDGE) ? w_wd : '0;
    assign w_data_rd   = (r_dir & r_data_out) | (~r_dir & w_in_sync);

    // Edge selection is fixed at elaboration.
    always_comb begin
        w_edge = w_rise | w_fall;
        if (EDGE_TYPE == 0)
            w_edge = w_rise;
        else if (EDGE_TYPE == 1)
            w_edge = w_fall;
    end

    // Input synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= '0;
            r_in_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_in_prev <= w_in_sync;
        end
    end

    // Register file; a new edge in the same cycle as a W1C wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= '0;
            r_irq_mask <= '0;
            r_blink_en <= '0;
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_wr) begin
                case (address)
                    A_DATA:   r_data_out <= w_wd;
                    A_DIR:    r_dir      <= w_wd;
                    A_MASK:   r_irq_mask <= w_wd;
                    A_OUTSET: r_data_out <= r_data_out | w_wd;
                    A_OUTCLR: r_data_out <= r_data_out & ~w_wd;
                    A_BLINK:  r_blink_en <= w_wd;
                    default:  ;
                endcase
            end
        end
    end

    // Free-running blink prescaler; phase toggles on each wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc       <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc       <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:  readdata = 32'(w_data_rd);
            A_DIR:   readdata = 32'(r_dir);
            A_MASK:  readdata = 32'(r_irq_mask);
            A_EDGE:  readdata = 32'(r_edge_cap);
            A_BLINK: readdata = 32'(r_blink_en);
            default: readdata = '0;
        endcase
    end

    assign out_port = r_data_out ^ (r_blink_en & {WIDTH{r_blink_phase}});
    assign oe       = r_dir;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
